// File: rtl/ram_1p_arbiter_pkg.sv
// ram_1p_arbiter_pkg
//
// Shared types and helpers for the single-port RAM arbiter.
// - DefWidth / DefDepth / DefAw : default data width, depth and word-address width.
// - BeW                         : byte-enable width at the default data width.
// - MaxBeW                      : widest byte-enable vector be2mask can expand.
// - req_t                       : one requester's access {we, addr, be, wdata}.
// - rsp_t                       : one response {rvalid, rdata}.
// - be2mask()                   : expands byte enables into a per-bit write mask.
package ram_1p_arbiter_pkg;

    localparam int DefWidth = 32;
    localparam int DefDepth = 128;
    localparam int DefAw    = $clog2(DefDepth);
    localparam int BeW      = DefWidth / 8;
    localparam int MaxBeW   = 64;

    typedef struct packed {
        logic              we;
        logic [DefAw-1:0]  addr;
        logic [BeW-1:0]    be;
        logic [DefWidth-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic                rvalid;
        logic [DefWidth-1:0] rdata;
    } rsp_t;

    // Each byte-enable bit is replicated across its 8-bit lane. Callers
    // zero-extend narrower enables and keep the low bits of the result.
    function automatic logic [8*MaxBeW-1:0] be2mask(input logic [MaxBeW-1:0] be);
        logic [8*MaxBeW-1:0] mask;
        mask = '0;
        for (int i = 0; i < MaxBeW; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_1p_arb_rr.sv
// ram_1p_arb_rr
//
// Single-winner arbiter with a rotating priority pointer.
// Configuration macro: RAM_1P_ARBITER_RR_EN
//   defined   : round-robin; prio_q holds the highest-priority index and moves
//               to winner+1 (wrapping) on every grant.
//   undefined : fixed priority, lowest index wins (plain priority encoder).
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset; also masks all requests
//   req_i   : request vector
//   gnt_o   : one-hot grant (or zero)
//   idx_o   : index of the winner (valid when valid_o)
//   valid_o : a grant is given this cycle
module ram_1p_arb_rr
    import ram_1p_arbiter_pkg::*;
#(
    parameter  int N    = 2,
    localparam int IdxW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] prio;

`ifdef RAM_1P_ARBITER_RR_EN
    logic [IdxW-1:0] prio_q;

    // NOTE: reset is sampled on the clock edge, so it sits inside the
    // edge-triggered block rather than in its sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q <= '0;
        end else if (valid_o) begin
            prio_q <= (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    assign prio = prio_q;
`else
    logic unused_clk;
    assign unused_clk = clk_i;
    assign prio       = '0;
`endif

    // Requests are blocked while reset is held so nothing is granted.
    logic [N-1:0] req_eff;
    assign req_eff = req_i & {N{rst_ni}};

    // Scan N candidates starting at the pointer; the first requester found wins.
    // NOTE: every combinational output gets a default before any branch so no
    // latch is inferred, and blocking assignments are used so later loop
    // iterations see the updated 'found'.
    always_comb begin
        int              sum;
        logic [IdxW-1:0] cand;
        logic            found;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        idx_o = '0;
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            sum  = int'(prio) + i;
            if (sum >= N) sum = sum - N;
            cand = IdxW'(sum);
            if (!found && req_eff[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (found) gnt_o[idx_o] = 1'b1;
        valid_o = found;
    end

endmodule

// File: rtl/ram_1p_arbiter.sv
// ram_1p_arbiter
//
// Shares one single-port, byte-masked SRAM with 1-cycle read latency between
// NumReq req/gnt/rvalid requesters. Arbitration, RAM-port mux, mask expansion
// and response routing. Arbitration policy selected by RAM_1P_ARBITER_RR_EN
// (see ram_1p_arb_rr). Width must be a multiple of 8 and at most 8*(MaxBeW-1).
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   req_i, we_i            : per-requester request / write enable
//   addr_i, be_i, wdata_i  : per-requester word address, byte enables, data
//   gnt_o                  : combinational grant, one-hot or zero
//   rvalid_o               : response strobe, one cycle after the grant
//   rdata_o                : shared read data, qualify with rvalid_o
//   ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o : RAM controls
//   ram_rdata_i            : RAM read data
module ram_1p_arbiter
    import ram_1p_arbiter_pkg::*;
#(
    parameter  int NumReq = 2,
    parameter  int Width  = DefWidth,
    parameter  int Depth  = DefDepth,
    localparam int Aw     = $clog2(Depth),
    localparam int ByteW  = Width / 8,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_i,
    input  logic [NumReq-1:0]                 we_i,
    input  logic [NumReq-1:0][Aw-1:0]         addr_i,
    input  logic [NumReq-1:0][ByteW-1:0]      be_i,
    input  logic [NumReq-1:0][Width-1:0]      wdata_i,
    output logic [NumReq-1:0]                 gnt_o,
    output logic [NumReq-1:0]                 rvalid_o,
    output logic [Width-1:0]                  rdata_o,
    output logic                              ram_req_o,
    output logic                              ram_write_o,
    output logic [Aw-1:0]                     ram_addr_o,
    output logic [Width-1:0]                  ram_wdata_o,
    output logic [Width-1:0]                  ram_wmask_o,
    input  logic [Width-1:0]                  ram_rdata_i
);

    logic [IdxW-1:0] arb_idx;
    logic            arb_valid;

    ram_1p_arb_rr #(.N(NumReq)) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // RAM port follows the winner; idle cycles drive zeros.
    logic [8*MaxBeW-1:0] mask_wide;

    always_comb begin
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        mask_wide   = '0;
        if (arb_valid) begin
            ram_req_o   = 1'b1;
            ram_write_o = we_i[arb_idx];
            ram_addr_o  = addr_i[arb_idx];
            ram_wdata_o = wdata_i[arb_idx];
            mask_wide   = be2mask(MaxBeW'(be_i[arb_idx]));
        end
    end

    assign ram_wmask_o = mask_wide[Width-1:0];

    logic unused_mask_hi;
    assign unused_mask_hi = ^mask_wide[8*MaxBeW-1:Width];

    // RAM latency is fixed at one cycle, so one pending slot is enough.
    logic            rsp_pend_q;
    logic [IdxW-1:0] rsp_idx_q;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_pend_q <= 1'b0;
            rsp_idx_q  <= '0;
        end else begin
            rsp_pend_q <= arb_valid;
            rsp_idx_q  <= arb_idx;
        end
    end

    // Gated by reset so a response in flight when reset arrives is dropped
    // immediately rather than one edge later.
    always_comb begin
        rvalid_o = '0;
        if (rst_ni && rsp_pend_q) rvalid_o[rsp_idx_q] = 1'b1;
    end

    assign rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// tb_ram_1p_arbiter
//
// Directed bench for ram_1p_arbiter with a behavioural byte-masked 1-cycle RAM
// attached to the RAM port. Expected responses are queued when a grant is
// expected and compared when the response cycle is reached.
// Expected arbitration order depends on RAM_1P_ARBITER_RR_EN.
module tb_ram_1p_arbiter;
    import ram_1p_arbiter_pkg::*;

    localparam int Aw = DefAw;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic [1:0]              req;
    logic [1:0]              we;
    logic [1:0][Aw-1:0]      addr;
    logic [1:0][BeW-1:0]     be;
    logic [1:0][DefWidth-1:0] wdata;
    logic [1:0]              gnt;
    logic [1:0]              rvalid;
    logic [DefWidth-1:0]     rdata;
    logic                    ram_req;
    logic                    ram_write;
    logic [Aw-1:0]           ram_addr;
    logic [DefWidth-1:0]     ram_wdata;
    logic [DefWidth-1:0]     ram_wmask;
    logic [DefWidth-1:0]     ram_rdata;

    req_t rq[2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            we[i]    = rq[i].we;
            addr[i]  = rq[i].addr;
            be[i]    = rq[i].be;
            wdata[i] = rq[i].wdata;
        end
    end

    ram_1p_arbiter #(.NumReq(2), .Width(DefWidth), .Depth(DefDepth)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .ram_req_o   (ram_req),
        .ram_write_o (ram_write),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wmask_o (ram_wmask),
        .ram_rdata_i (ram_rdata)
    );

    // Behavioural RAM with a backdoor write port for preloading.
    logic [DefWidth-1:0] mem [DefDepth];
    logic                bd_we;
    logic [Aw-1:0]       bd_addr;
    logic [DefWidth-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_req) begin
            if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            else           ram_rdata <= mem[ram_addr];
        end
    end

    // Reference memory and response scoreboard.
    typedef struct {
        int   idx;
        bit   rd;
        rsp_t rsp;
    } exp_t;

    logic [DefWidth-1:0] ref_mem [DefDepth];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [Aw-1:0] a, input logic [DefWidth-1:0] d);
        bd_we      = 1'b1;
        bd_addr    = a;
        bd_data    = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    // One clock cycle: compare the response owed from the previous cycle,
    // compare this cycle's grant, queue the response this grant will produce.
    task automatic cycle(input string tag, input logic [1:0] exp_gnt);
        exp_t e;
        int   w;
        @(negedge clk);
        if (!rst_ni) sb.delete();
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".rvalid"}, 32'(rvalid), 32'(2'b01 << e.idx));
            if (e.rd) check({tag, ".rdata"}, rdata, e.rsp.rdata);
        end else begin
            check({tag, ".rvalid_idle"}, 32'(rvalid), 32'h0);
        end
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, ".ram_req"}, 32'(ram_req), 32'(exp_gnt != 2'b00));
        if (exp_gnt != 2'b00) begin
            w            = exp_gnt[1] ? 1 : 0;
            e.idx        = w;
            e.rd         = !rq[w].we;
            e.rsp.rvalid = 1'b1;
            e.rsp.rdata  = ref_mem[rq[w].addr];
            if (rq[w].we) begin
                for (int b = 0; b < BeW; b++) begin
                    if (rq[w].be[b]) ref_mem[rq[w].addr][8*b +: 8] = rq[w].wdata[8*b +: 8];
                end
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] contend_gnt(input int i);
`ifdef RAM_1P_ARBITER_RR_EN
        return (i % 2 == 0) ? 2'b01 : 2'b10;
`else
        return (i >= 0) ? 2'b01 : 2'b10;
`endif
    endfunction

    initial begin
        rst_ni = 1'b0;
        bd_we  = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        req    = 2'b11;
        rq[0]  = '{we: 1'b0, addr: 7'd5, be: 4'hF, wdata: 32'h0};
        rq[1]  = '{we: 1'b0, addr: 7'd3, be: 4'hF, wdata: 32'h0};
        @(posedge clk);
        #1;

        // Reset: requests present but nothing granted or acknowledged.
        cycle("reset0", 2'b00);
        cycle("reset1", 2'b00);
        rst_ni = 1'b1;
        req    = 2'b00;

        preload(7'd5, 32'hDEADBEEF);
        preload(7'd0, 32'h01234567);
        preload(7'd1, 32'h89ABCDEF);
        preload(7'd2, 32'hCAFEF00D);
        preload(7'd3, 32'hFFFFFFFF);
        preload(7'd7, 32'hA5A5A5A5);

        // Contention: both requesters read continuously for six cycles.
        req = 2'b11;
        for (int i = 0; i < 6; i++) cycle($sformatf("contend%0d", i), contend_gnt(i));
        req = 2'b00;
        cycle("contend_idle", 2'b00);

        // Single read of addr 5 by requester 0.
        rq[0] = '{we: 1'b0, addr: 7'd5, be: 4'hF, wdata: 32'h0};
        req   = 2'b01;
        cycle("rd5", 2'b01);
        req = 2'b00;
        cycle("rd5_idle", 2'b00);

        // Back-to-back reads of addresses 0..3.
        req = 2'b01;
        for (int a = 0; a < 4; a++) begin
            rq[0].addr = 7'(a);
            cycle($sformatf("b2b%0d", a), 2'b01);
        end
        req = 2'b00;
        cycle("b2b_idle", 2'b00);

        // Byte write by requester 1, then read back.
        rq[1] = '{we: 1'b1, addr: 7'd3, be: 4'b0101, wdata: 32'h11223344};
        req   = 2'b10;
        cycle("bwr3", 2'b10);
        req = 2'b00;
        cycle("bwr3_idle", 2'b00);
        rq[0] = '{we: 1'b0, addr: 7'd3, be: 4'hF, wdata: 32'h0};
        req   = 2'b01;
        cycle("rd3", 2'b01);
        req = 2'b00;
        cycle("rd3_idle", 2'b00);
        check("mem3", mem[3], 32'hFF22FF44);

        // Write with no byte enables leaves the word unchanged.
        rq[0] = '{we: 1'b1, addr: 7'd7, be: 4'b0000, wdata: 32'h00000000};
        req   = 2'b01;
        cycle("be0wr7", 2'b01);
        req = 2'b00;
        cycle("be0wr7_idle", 2'b00);
        rq[0] = '{we: 1'b0, addr: 7'd7, be: 4'hF, wdata: 32'h0};
        req   = 2'b01;
        cycle("rd7", 2'b01);
        req = 2'b00;
        cycle("rd7_idle", 2'b00);
        check("mem7", mem[7], 32'hA5A5A5A5);

        // Reset right after a grant: response dropped, pointer back to 0.
        rq[0] = '{we: 1'b0, addr: 7'd5, be: 4'hF, wdata: 32'h0};
        rq[1] = '{we: 1'b0, addr: 7'd3, be: 4'hF, wdata: 32'h0};
        req   = 2'b01;
        cycle("pre_rst", 2'b01);
        rst_ni = 1'b0;
        req    = 2'b11;
        cycle("mid_rst0", 2'b00);
        cycle("mid_rst1", 2'b00);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) cycle($sformatf("post_rst%0d", i), contend_gnt(i));
        req = 2'b00;
        cycle("post_rst_idle", 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
